// File: rtl/generic_divider_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | generic_divider_pkg: shared state encodings for the divider        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package generic_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/generic_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | generic_subtractor: S = A - B as A + ~B + 1 over a full-adder chain|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module generic_subtractor #(
  parameter int w = 9
) (
  input  logic [w-1:0] A,
  input  logic [w-1:0] B,
  output logic [w-1:0] S,
  output logic         borrowout
);

  logic [w:0]   carry;
  logic [w-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~B;

  for (genvar i = 0; i < w; i++) begin : g_fa
    assign S[i]       = A[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (A[i] & b_inv[i]) | (carry[i] & (A[i] ^ b_inv[i]));
  end

  // No carry out of the top bit means A < B.
  assign borrowout = ~carry[w];

endmodule
`default_nettype wire

// File: rtl/generic_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | generic_divider: iterative restoring unsigned divider, 1 bit/clock |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module generic_divider
  import generic_divider_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         divByZero
);

  localparam int CW = $clog2(n + 1);

  state_t          state;
  state_t          state_next;
  logic [n:0]      r;
  logic [n-1:0]    q;
  logic [n-1:0]    d;
  logic [CW-1:0]   cnt;
  logic [n:0]      rs;
  logic [n:0]      diff;
  logic            borrow;
  logic [n:0]      r_next;
  logic [n-1:0]    q_next;
  logic            zero_div;
  logic            last_iter;
  logic            unused_r_msb;

  // The top bit of R is always zero once an iteration settles.
  assign unused_r_msb = r[n];
  assign rs           = {r[n-1:0], q[n-1]};

  generic_subtractor #(
    .w(n + 1)
  ) u_sub (
    .A        (rs),
    .B        ({1'b0, d}),
    .S        (diff),
    .borrowout(borrow)
  );

  assign r_next    = borrow ? rs : diff;
  assign q_next    = {q[n-2:0], ~borrow};
  assign zero_div  = (cnt == CW'(n)) && (d == '0);
  assign last_iter = (cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_DIVIDE;
      ST_DIVIDE: if (zero_div || last_iter) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            q         <= dividend;
            d         <= divisor;
            r         <= '0;
            cnt       <= CW'(n);
            busy      <= 1'b1;
            divByZero <= 1'b0;
          end
        end
        ST_DIVIDE: begin
          if (zero_div) begin
            // Q still holds the untouched dividend on the first iteration.
            quotient  <= '1;
            remainder <= q;
            divByZero <= 1'b1;
            done      <= 1'b1;
          end else begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt - CW'(1);
            if (last_iter) begin
              quotient  <= q_next;
              remainder <= r_next[n-1:0];
              done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generic_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_generic_divider: directed and swept checks of generic_divider   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_generic_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       divByZero;

  int total = 0;
  int bad   = 0;

  generic_divider #(.n(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      cyc = k;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int edz, input int elat);
    int cyc;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    check("busy_on", busy, 1);
    wait_done(cyc);
    check("latency", cyc, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("divbyzero", divByZero, edz);
    tick();
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
  endtask

  initial begin
    int cyc;
    int seen;
    int a;
    int b;

    repeat (2) tick();
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", divByZero, 0);
    reset = 1'b1;
    tick();

    run_div(8'd100, 8'd7, 14, 2, 0, 8);
    run_div(8'd255, 8'd1, 255, 0, 0, 8);
    run_div(8'd255, 8'd255, 1, 0, 0, 8);
    run_div(8'd5, 8'd9, 0, 5, 0, 8);
    run_div(8'd0, 8'd3, 0, 0, 0, 8);
    run_div(8'd200, 8'd0, 255, 200, 1, 1);
    run_div(8'd10, 8'd3, 3, 1, 0, 8);

    // A start pulse during the divide must be ignored.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check("intf_latency", cyc, 4);
    check("intf_quotient", quotient, 14);
    check("intf_remainder", remainder, 2);
    tick();
    check("intf_busy_off", busy, 0);

    // Reset in the middle of a divide clears everything at once.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("mrst_quotient", quotient, 0);
    check("mrst_remainder", remainder, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_dz", divByZero, 0);
    repeat (2) tick();
    reset = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("mrst_idle", seen, 0);

    // Start held high: second divide accepted as soon as the block idles.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    dividend = 8'd77; divisor = 8'd5;
    wait_done(cyc);
    check("b2b_lat1", cyc, 8);
    check("b2b_q1", quotient, 14);
    check("b2b_r1", remainder, 2);
    wait_done(cyc);
    start = 1'b0;
    check("b2b_gap", cyc, 10);
    check("b2b_q2", quotient, 15);
    check("b2b_r2", remainder, 2);
    tick();
    check("b2b_busy_off", busy, 0);
    tick();

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (b == 0)
        run_div(8'(a), 8'(b), 255, a, 1, 1);
      else
        run_div(8'(a), 8'(b), a / b, a % b, 0, 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
